stream_burst_source: RTL and testbench

Valid/ready stream transmitter. It accepts a burst command (base, stride, length) on a command handshake and emits the burst as a sequence of data beats on a valid/ready output stream, with a last-beat flag. It sits upstream of the pipeline registers and stream sinks, and drives the same ready/valid protocol as the producer end. It is used as a DMA-style traffic source and as a bring-up pattern generator.

---
 rtl/stream_burst_source_if.sv | 30 +++
 rtl/stream_burst_source.sv | 117 +++++++++++
 tb/tb_stream_burst_source.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_burst_source_if.sv
// stream_burst_source_if
// Groups the two handshakes of the burst source: the command channel
// (base/stride/length offered with cmd_valid/cmd_ready) and the output beat
// stream (out_valid/out_ready with out_data/out_last).
//   master : the burst source itself (takes commands, drives beats)
//   slave  : the environment (offers commands, consumes beats)
interface stream_burst_source_if #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_base;
  logic [WIDTH-1:0] cmd_stride;
  logic [LEN_W-1:0] cmd_len;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len, out_ready,
    output cmd_ready, out_valid, out_data, out_last
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_stride, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/stream_burst_source.sv
// stream_burst_source
// Accepts a burst command (base, stride, length-1) and emits the burst as a
// sequence of valid/ready beats: base, base+stride, base+2*stride, ... with
// out_last on the final beat. Used as a DMA-style traffic source and as a
// bring-up pattern generator.
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset (aborts any burst in flight)
//   bus         command channel + output beat stream (master side)
//   busy        burst in progress, identical to out_valid
//   done        one-cycle pulse after the last beat is accepted
//   burst_count completed bursts, wraps modulo 2^CNT_W
module stream_burst_source #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  stream_burst_source_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      burst_count
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             cmd_accept;
  logic             beat_accept;

  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH-1:0] stride_q;
  logic [LEN_W-1:0] remaining_q;
  logic             out_last_q;
  logic             done_q;
  logic [CNT_W-1:0] burst_count_q;

  // A beat is presented for the whole time the FSM is in RUN, so out_valid
  // is simply the state; it cannot drop before its handshake because RUN is
  // only left on the last-beat handshake.
  assign bus.cmd_ready = (state == IDLE);
  assign bus.out_valid = (state == RUN);
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign busy          = (state == RUN);
  assign done          = done_q;
  assign burst_count   = burst_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    cmd_accept  = 1'b0;
    beat_accept = 1'b0;
    case (state)
      IDLE: begin
        if (bus.cmd_valid) begin
          cmd_accept = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (bus.out_ready) begin
          beat_accept = 1'b1;
          if (out_last_q) begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat datapath. out_data/out_last only move on a command or a handshake,
  // which keeps them frozen under backpressure. remaining counts the beats
  // still to come after the one currently presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q    <= '0;
      stride_q      <= '0;
      remaining_q   <= '0;
      out_last_q    <= 1'b0;
      done_q        <= 1'b0;
      burst_count_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (cmd_accept) begin
        out_data_q  <= bus.cmd_base;
        stride_q    <= bus.cmd_stride;
        remaining_q <= bus.cmd_len;
        out_last_q  <= (bus.cmd_len == '0);
      end else if (beat_accept) begin
        if (out_last_q) begin
          out_last_q    <= 1'b0;
          done_q        <= 1'b1;
          burst_count_q <= burst_count_q + CNT_W'(1);
        end else begin
          out_data_q  <= out_data_q + stride_q;
          remaining_q <= remaining_q - LEN_W'(1);
          out_last_q  <= (remaining_q == LEN_W'(1));
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_burst_source.sv
// tb_stream_burst_source
// Directed bench for stream_burst_source: single beat, four-beat burst,
// backpressure, address wrap with back-to-back commands, maximum length,
// completion-counter wrap and reset in the middle of a burst. The counter is
// instantiated narrow so its wrap is reachable in a short run.
module tb_stream_burst_source;

  localparam int WIDTH = 32;
  localparam int LEN_W = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] burst_count;

  int total;
  int bad;

  stream_burst_source_if #(.WIDTH(WIDTH), .LEN_W(LEN_W)) bus ();

  stream_burst_source #(
    .WIDTH(WIDTH),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .busy        (busy),
    .done        (done),
    .burst_count (burst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic cv, input logic [WIDTH-1:0] base,
                               input logic [WIDTH-1:0] stride,
                               input logic [LEN_W-1:0] len, input logic ordy);
    bus.cmd_valid  = cv;
    bus.cmd_base   = base;
    bus.cmd_stride = stride;
    bus.cmd_len    = len;
    bus.out_ready  = ordy;
  endtask

  initial begin
    logic [WIDTH-1:0] exp_data;
    logic [CNT_W-1:0] exp_count;
    bit               pat [7];
    int               k;

    total     = 0;
    bad       = 0;
    exp_count = '0;
    pat       = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    rst_n = 1'b0;
    applyStimulus(1'b0, '0, '0, '0, 1'b0);
    #12;
    checkOutput("rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("rst_last", 64'(bus.out_last), 64'd0);
    checkOutput("rst_data", 64'(bus.out_data), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_count", 64'(burst_count), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    // Single beat.
    applyStimulus(1'b1, 32'h10, 32'h4, 8'd0, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("single_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("single_data", 64'(bus.out_data), 64'h10);
    checkOutput("single_last", 64'(bus.out_last), 64'd1);
    checkOutput("single_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    @(negedge clk);
    exp_count = exp_count + 1'b1;
    checkOutput("single_after_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("single_done", 64'(done), 64'd1);
    checkOutput("single_count", 64'(burst_count), 64'(exp_count));
    checkOutput("single_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    checkOutput("single_done_cleared", 64'(done), 64'd0);

    // Four-beat burst at full rate.
    applyStimulus(1'b1, 32'h100, 32'h20, 8'd3, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    exp_data = 32'h100;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("four_valid%0d", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("four_data%0d", i), 64'(bus.out_data), 64'(exp_data));
      checkOutput($sformatf("four_last%0d", i), 64'(bus.out_last), 64'(i == 3));
      checkOutput($sformatf("four_done%0d", i), 64'(done), 64'd0);
      exp_data = exp_data + 32'h20;
      @(negedge clk);
    end
    exp_count = exp_count + 1'b1;
    checkOutput("four_end_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("four_done", 64'(done), 64'd1);
    checkOutput("four_count", 64'(burst_count), 64'(exp_count));

    // Same burst under backpressure 1,0,0,1,0,1,1.
    applyStimulus(1'b1, 32'h100, 32'h20, 8'd3, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 7; c++) begin
      bus.out_ready = pat[c];
      checkOutput($sformatf("bp_valid%0d", c), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("bp_data%0d", c), 64'(bus.out_data), 64'(32'h100 + 32'h20 * k));
      checkOutput($sformatf("bp_last%0d", c), 64'(bus.out_last), 64'(k == 3));
      if (pat[c]) k++;
      @(negedge clk);
    end
    exp_count = exp_count + 1'b1;
    checkOutput("bp_end_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("bp_done", 64'(done), 64'd1);
    checkOutput("bp_count", 64'(burst_count), 64'(exp_count));

    // Data wrap, with a second command held waiting during the burst.
    applyStimulus(1'b1, 32'hFFFF_FFFE, 32'h1, 8'd3, 1'b1);
    @(negedge clk);
    bus.cmd_base   = 32'h500;
    bus.cmd_stride = 32'h3;
    bus.cmd_len    = 8'd1;
    exp_data = 32'hFFFF_FFFE;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wrap_data%0d", i), 64'(bus.out_data), 64'(exp_data));
      checkOutput($sformatf("wrap_last%0d", i), 64'(bus.out_last), 64'(i == 3));
      exp_data = exp_data + 32'h1;
      @(negedge clk);
    end
    exp_count = exp_count + 1'b1;
    checkOutput("b2b_bubble_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("b2b_bubble_done", 64'(done), 64'd1);
    checkOutput("b2b_bubble_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    checkOutput("b2b_bubble_count", 64'(burst_count), 64'(exp_count));
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("b2b_first_valid", 64'(bus.out_valid), 64'd1);
    checkOutput("b2b_first_data", 64'(bus.out_data), 64'h500);
    checkOutput("b2b_first_last", 64'(bus.out_last), 64'd0);
    checkOutput("b2b_first_done", 64'(done), 64'd0);
    @(negedge clk);
    checkOutput("b2b_second_data", 64'(bus.out_data), 64'h503);
    checkOutput("b2b_second_last", 64'(bus.out_last), 64'd1);
    @(negedge clk);
    exp_count = exp_count + 1'b1;
    checkOutput("b2b_done", 64'(done), 64'd1);
    checkOutput("b2b_count", 64'(burst_count), 64'(exp_count));

    // Maximum length burst: 256 beats 0..255.
    applyStimulus(1'b1, 32'h0, 32'h1, 8'd255, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      checkOutput($sformatf("max_valid%0d", i), 64'(bus.out_valid), 64'd1);
      checkOutput($sformatf("max_data%0d", i), 64'(bus.out_data), 64'(i));
      if (i >= 254)
        checkOutput($sformatf("max_last%0d", i), 64'(bus.out_last), 64'(i == 255));
      @(negedge clk);
    end
    exp_count = exp_count + 1'b1;
    checkOutput("max_end_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("max_done", 64'(done), 64'd1);
    checkOutput("max_count", 64'(burst_count), 64'(exp_count));

    // Single-beat bursts until the completion counter passes 15 -> 0.
    for (int j = 0; j < 10; j++) begin
      applyStimulus(1'b1, 32'(j), 32'h0, 8'd0, 1'b1);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      checkOutput($sformatf("cnt_last%0d", j), 64'(bus.out_last), 64'd1);
      @(negedge clk);
      exp_count = exp_count + 1'b1;
      checkOutput($sformatf("cnt_count%0d", j), 64'(burst_count), 64'(exp_count));
    end
    checkOutput("cnt_wrapped", 64'(burst_count), 64'd0);

    // Reset asserted while beat 2 of an 8-beat burst is presented.
    applyStimulus(1'b1, 32'h1000, 32'h10, 8'd7, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_beat1_data", 64'(bus.out_data), 64'h1010);
    @(negedge clk);
    checkOutput("mid_beat2_data", 64'(bus.out_data), 64'h1020);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    checkOutput("mid_rst_last", 64'(bus.out_last), 64'd0);
    checkOutput("mid_rst_data", 64'(bus.out_data), 64'd0);
    checkOutput("mid_rst_done", 64'(done), 64'd0);
    checkOutput("mid_rst_busy", 64'(busy), 64'd0);
    checkOutput("mid_rst_count", 64'(burst_count), 64'd0);
    checkOutput("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_done", 64'(done), 64'd0);
    checkOutput("post_rst_count", 64'(burst_count), 64'd0);
    checkOutput("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    applyStimulus(1'b1, 32'h77, 32'h1, 8'd1, 1'b1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    checkOutput("post_rst_data0", 64'(bus.out_data), 64'h77);
    checkOutput("post_rst_last0", 64'(bus.out_last), 64'd0);
    @(negedge clk);
    checkOutput("post_rst_data1", 64'(bus.out_data), 64'h78);
    checkOutput("post_rst_last1", 64'(bus.out_last), 64'd1);
    @(negedge clk);
    checkOutput("post_rst_done_pulse", 64'(done), 64'd1);
    checkOutput("post_rst_count_one", 64'(burst_count), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
